// File: rtl/clk_enable_gen.sv
// clk_enable_gen: derives NUM_CH divided clock-enables and square waves
// from refclk. Each channel has a programmable divide ratio and phase
// delay held in shadow registers; a resync pulse realigns all channels
// through a one-cycle ALIGN state that loads the shadow configuration.
//
// Configuration write protocol: cfg_we is a single-cycle strobe with no
// ready/back-pressure. A write is accepted on every rising refclk edge where
// cfg_we=1 and cfg_ch<NUM_CH; other channel indices are silently dropped.
// resync is a pulse sampled on the same edge; a write on that edge is
// visible to the ALIGN that the resync starts.
module clk_enable_gen #(
    parameter int                      NUM_CH      = 2,
    parameter int                      CNT_W       = 8,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT    = {8'd12, 8'd6},
    parameter logic [NUM_CH*CNT_W-1:0] PHASE_INIT  = {8'd3, 8'd0},
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked,
    output logic              dbg_state
);

    localparam int LW = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {
        ALIGN = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_nx;

    // Shadow configuration, written by cfg_we, consumed only at ALIGN.
    logic [CNT_W-1:0] sh_div [NUM_CH];
    logic [CNT_W-1:0] sh_ph  [NUM_CH];

    // Active divide ratio; phase is consumed directly into rem_q at ALIGN.
    logic [CNT_W-1:0] act_div [NUM_CH];

    // Per-channel position for the current cycle: idle_q marks the phase
    // delay, rem_q counts idle cycles still to come, pos_q is the index
    // within the period.
    logic [NUM_CH-1:0] idle_q;
    logic [CNT_W-1:0]  rem_q  [NUM_CH];
    logic [CNT_W-1:0]  pos_q  [NUM_CH];

    // Next-cycle values.
    logic [NUM_CH-1:0] nx_idle;
    logic [NUM_CH-1:0] nx_ce;
    logic [NUM_CH-1:0] nx_clk;
    logic [CNT_W-1:0]  nx_rem  [NUM_CH];
    logic [CNT_W-1:0]  nx_pos  [NUM_CH];
    logic [CNT_W-1:0]  src_div [NUM_CH];
    logic [CNT_W-1:0]  ld_ph   [NUM_CH];

    logic [LW-1:0] lock_cnt;
    logic [LW-1:0] lock_nx;

    assign dbg_state = (state == RUN);

    // State register; reset lands in ALIGN so the first cycle realigns.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ALIGN;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: ALIGN always advances to RUN; resync forces ALIGN.
    always_comb begin
        state_nx = RUN;
        if (resync) begin
            state_nx = ALIGN;
        end
    end

    // Shadow configuration registers with INIT values on reset.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_div[i] <= DIV_INIT[i*CNT_W +: CNT_W];
                sh_ph[i]  <= PHASE_INIT[i*CNT_W +: CNT_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (cfg_we && (cfg_ch == 3'(i))) begin
                    sh_div[i] <= cfg_div;
                    sh_ph[i]  <= cfg_phase;
                end
            end
        end
    end

    // Channel sequencing: compute the position and outputs of the next cycle
    // so that ce/clk_out can be registered straight to the pins.
    always_comb begin
        nx_idle = '0;
        nx_ce   = '0;
        nx_clk  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            src_div[i] = (state == ALIGN) ? sh_div[i] : act_div[i];
            // A phase at or beyond the period collapses to zero.
            ld_ph[i]   = ((sh_div[i] != '0) && (sh_ph[i] >= sh_div[i])) ? '0 : sh_ph[i];
            nx_rem[i]  = '0;
            nx_pos[i]  = '0;
            if (state == ALIGN) begin
                if (ld_ph[i] != '0) begin
                    nx_idle[i] = 1'b1;
                    nx_rem[i]  = ld_ph[i] - CNT_W'(1);
                end
            end else if (idle_q[i]) begin
                if (rem_q[i] != '0) begin
                    nx_idle[i] = 1'b1;
                    nx_rem[i]  = rem_q[i] - CNT_W'(1);
                end
            end else if (pos_q[i] != (src_div[i] - CNT_W'(1))) begin
                nx_pos[i] = pos_q[i] + CNT_W'(1);
            end
            if ((src_div[i] != '0) && !nx_idle[i]) begin
                nx_ce[i]  = (nx_pos[i] == (src_div[i] - CNT_W'(1)));
                nx_clk[i] = (nx_pos[i] < (src_div[i] >> 1));
            end
        end
    end

    // Channel registers: cleared by reset/resync, loaded at ALIGN, stepped in RUN.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q  <= '0;
            ce      <= '0;
            clk_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                act_div[i] <= '0;
                rem_q[i]   <= '0;
                pos_q[i]   <= '0;
            end
        end else if (resync) begin
            idle_q  <= '0;
            ce      <= '0;
            clk_out <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                rem_q[i] <= '0;
                pos_q[i] <= '0;
            end
        end else begin
            idle_q  <= nx_idle;
            ce      <= nx_ce;
            clk_out <= nx_clk;
            for (int i = 0; i < NUM_CH; i++) begin
                if (state == ALIGN) begin
                    act_div[i] <= sh_div[i];
                end
                rem_q[i] <= nx_rem[i];
                pos_q[i] <= nx_pos[i];
            end
        end
    end

    // Saturating count of cycles since ALIGN; lock_cnt equals the current
    // cycle's offset from ALIGN.
    always_comb begin
        lock_nx = lock_cnt;
        if (state == ALIGN) begin
            lock_nx = LW'(1);
        end else if (lock_cnt != LW'(LOCK_CYCLES)) begin
            lock_nx = lock_cnt + LW'(1);
        end
    end

    // Lock counter and registered locked flag.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else if (resync) begin
            lock_cnt <= '0;
            locked   <= 1'b0;
        end else begin
            lock_cnt <= lock_nx;
            locked   <= (lock_nx == LW'(LOCK_CYCLES));
        end
    end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: each sampled cycle is compared against
// a modular-arithmetic reference of the channel timing relative to ALIGN.
module tb_clk_enable_gen;

    logic       refclk;
    logic       rst_n;
    logic       resync;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_div;
    logic [7:0] cfg_phase;
    logic [1:0] ce;
    logic [1:0] clk_out;
    logic       locked;
    logic       dbg_state;

    int checks;
    int failures;
    int k_rel;
    int cur_d [2];
    int cur_p [2];
    int sh_d  [2];
    int sh_p  [2];

    clk_enable_gen dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .resync    (resync),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_phase (cfg_phase),
        .ce        (ce),
        .clk_out   (clk_out),
        .locked    (locked),
        .dbg_state (dbg_state)
    );

    // clock
    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic set_defaults();
        sh_d[0] = 6;  sh_p[0] = 0;
        sh_d[1] = 12; sh_p[1] = 3;
        cur_d[0] = 6;  cur_p[0] = 0;
        cur_d[1] = 12; cur_p[1] = 3;
    endtask

    // Reference: cycle k after ALIGN, divide d, phase p.
    task automatic model(input int k, output logic [1:0] e_ce, output logic [1:0] e_clk);
        int d, p, m;
        e_ce  = '0;
        e_clk = '0;
        for (int c = 0; c < 2; c++) begin
            d = cur_d[c];
            p = (d != 0 && cur_p[c] >= d) ? 0 : cur_p[c];
            if (d != 0 && k > p) begin
                m = (k - p - 1) % d;
                e_ce[c]  = (m == d - 1);
                e_clk[c] = (m < d / 2);
            end
        end
    endtask

    task automatic check_now();
        logic [1:0] e_ce, e_clk;
        logic       e_lock, e_st;
        model(k_rel, e_ce, e_clk);
        e_lock = (k_rel >= 16);
        e_st   = (k_rel >= 1);
        checks++;
        assert (ce === e_ce) else begin
            failures++;
            $error("FAIL ce k=%0d got=%b exp=%b", k_rel, ce, e_ce);
        end
        checks++;
        assert (clk_out === e_clk) else begin
            failures++;
            $error("FAIL clk_out k=%0d got=%b exp=%b", k_rel, clk_out, e_clk);
        end
        checks++;
        assert (locked === e_lock) else begin
            failures++;
            $error("FAIL locked k=%0d got=%b exp=%b", k_rel, locked, e_lock);
        end
        checks++;
        assert (dbg_state === e_st) else begin
            failures++;
            $error("FAIL state k=%0d got=%b exp=%b", k_rel, dbg_state, e_st);
        end
    endtask

    task automatic check_zero(input string tag);
        checks++;
        assert ({ce, clk_out, locked} === 5'b0) else begin
            failures++;
            $error("FAIL %s got ce=%b clk_out=%b locked=%b exp all 0", tag, ce, clk_out, locked);
        end
        checks++;
        assert (dbg_state === 1'b0) else begin
            failures++;
            $error("FAIL %s_state got=%b exp=0", tag, dbg_state);
        end
    endtask

    // driver: advance one cycle, release strobes, sample at negedge
    task automatic step_check();
        @(posedge refclk);
        #1;
        cfg_we = 1'b0;
        resync = 1'b0;
        k_rel++;
        @(negedge refclk);
        check_now();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_check();
    endtask

    task automatic cfg_set(input int ch, input int d, input int p);
        cfg_we    = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = 8'(d);
        cfg_phase = 8'(p);
        if (ch < 2) begin
            sh_d[ch] = d;
            sh_p[ch] = p;
        end
    endtask

    task automatic cfg_write(input int ch, input int d, input int p);
        cfg_set(ch, d, p);
        step_check();
    endtask

    task automatic resync_now();
        resync = 1'b1;
        @(posedge refclk);
        #1;
        resync = 1'b0;
        cfg_we = 1'b0;
        cur_d[0] = sh_d[0]; cur_p[0] = sh_p[0];
        cur_d[1] = sh_d[1]; cur_p[1] = sh_p[1];
        k_rel = 0;
        @(negedge refclk);
        check_now();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        k_rel     = 0;
        rst_n     = 1'b0;
        resync    = 1'b0;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        cfg_phase = '0;
        set_defaults();

        // reset state and defaults after release
        repeat (3) @(posedge refclk);
        @(negedge refclk);
        check_zero("reset");
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        k_rel = 0;
        @(negedge refclk);
        check_now();
        run(40);

        // shadow write without resync leaves ch0 unchanged, then takes effect
        cfg_write(0, 4, 0);
        run(19);
        resync_now();
        run(30);

        // ch1 disabled; lock still asserts
        cfg_write(1, 0, 0);
        resync_now();
        run(30);

        // ch0 divide of 1
        cfg_write(0, 1, 0);
        resync_now();
        run(20);

        // ch0 phase beyond divide, ch1 restored with phase
        cfg_write(0, 6, 7);
        cfg_write(1, 12, 3);
        resync_now();
        run(25);

        // out-of-range channel write is dropped; write in same cycle as resync
        cfg_write(5, 9, 9);
        cfg_set(0, 5, 2);
        resync_now();
        run(25);

        // back-to-back resync
        cfg_write(0, 7, 1);
        resync_now();
        resync_now();
        run(25);

        // async reset mid-period, then default timing again
        run(3);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge refclk);
        #1;
        rst_n = 1'b1;
        set_defaults();
        k_rel = 0;
        @(negedge refclk);
        check_now();
        run(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised, fully synchronous clock-enable generator. It derives NUM_CH divided clock-enables and square-wave outputs from one reference clock.
- Each channel has a programmable integer divide ratio and phase delay. Channels realign together on command, and a lock indicator is provided.
- Successor to the fixed two-output core PLL wrapper: it sits behind the PLL and produces the low-rate video/CPU enables (e.g. 8 MHz / 4 MHz from 48 MHz) without extra PLL outputs.

Parameters:
- NUM_CH, 2, number of output channels (1..8).
- CNT_W, 8, width of the divide and phase fields.
- DIV_INIT, {8'd12, 8'd6}, packed NUM_CH*CNT_W reset divide ratios; channel 0 in the LSBs.
- PHASE_INIT, {8'd3, 8'd0}, packed NUM_CH*CNT_W reset phase delays in refclk cycles.
- LOCK_CYCLES, 16, number of RUN cycles after alignment before locked asserts (≥1).

Ports:
- refclk  in  1  reference clock; all logic is on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- resync  in  1  single-cycle pulse: realign all channels and apply the shadow configuration.
- cfg_we  in  1  write strobe for the shadow configuration.
- cfg_ch  in  3  channel index for cfg_we.
- cfg_div  in  CNT_W  divide ratio to write.
- cfg_phase  in  CNT_W  phase delay to write.
- ce  out  NUM_CH  one-refclk-cycle enable pulse per channel.
- clk_out  out  NUM_CH  registered square wave per channel.
- locked  out  1  all channels aligned and stable.

Behaviour:
- Interface:
  - One clock, refclk.
  - Reset rst_n is asynchronous and active-low.
  - While rst_n=0: ce=0, clk_out=0, locked=0, state=ALIGN, shadow div/phase = DIV_INIT/PHASE_INIT.
- Shadow configuration:
  - cfg_we=1 with cfg_ch<NUM_CH writes div/phase into that channel's shadow register.
  - cfg_ch≥NUM_CH: the write is ignored.
  - Shadow values never affect running counters until the next ALIGN.
- States: ALIGN, RUN.
  - ALIGN lasts exactly 1 cycle. It loads each channel's active div/phase from the shadow registers and clears all counters. ce=0 and clk_out=0 during ALIGN. Next state is RUN.
  - RUN: channels count; the lock counter increments, saturating at LOCK_CYCLES.
  - resync=1 sampled in any state: next state is ALIGN, and locked clears at the same edge.
  - The first cycle after rst_n release is ALIGN.
- Simultaneous cfg_we and resync: the write lands in shadow at that edge, and the following ALIGN uses the new value.
- Channel timing, with cycle A = the ALIGN cycle, and active div D and phase P:
  - Cycles A+1 .. A+P: channel idle (ce=0, clk_out=0).
  - From A+P+1, a period of D cycles repeats: clk_out=1 for the first floor(D/2) cycles and 0 for the rest; ce=1 on the last cycle of each period.
  - First ce pulse is at A+P+D.
  - All outputs are registers (no combinational decode to pins).
- Boundary values of D and P:
  - D=0: channel disabled; ce=0, clk_out=0 permanently until the next ALIGN.
  - D=1: ce=1 every RUN cycle after the phase delay; clk_out=0.
  - P≥D (with D≠0): P is treated as 0.
- Counters: wrap from D-1 to 0 with no lost or doubled cycle. Internal arithmetic is CNT_W bits with no overflow, since D ≤ 2^CNT_W-1.
- locked:
  - Goes to 1 in cycle A+LOCK_CYCLES and stays 1 until reset or resync.
  - Disabled channels do not block lock.
- Reset mid-operation: outputs return to reset values immediately (asynchronously), and shadow returns to the INIT values. Configuration written before reset is lost.

Test Plan:
- Reset release with defaults (D0=6/P0=0, D1=12/P1=3), checked relative to the ALIGN cycle A after release:
  - ce[0] high at A+6, A+12, A+18 …
  - clk_out[0] high for A+1..A+3, then low for A+4..A+6, repeating.
  - ce[1] first high at A+15, then every 12 cycles.
  - locked rises at A+16.
- Config write without resync: cfg_we, ch0, div=4 during RUN → no change to ch0 period. Then resync → ce[0] period becomes 4, first pulse at A'+4, and locked drops and re-rises 16 cycles after A'.
- Boundary divides and phases:
  - ch1 div=0 + resync → ce[1] and clk_out[1] stay 0; locked still asserts.
  - ch0 div=1 → ce[0] constantly 1 in RUN, clk_out[0]=0.
  - ch0 phase=7 with div=6 → behaves as phase 0.
- Ignored write and same-cycle write: cfg_ch=5 write is ignored. A cfg_we asserted in the same cycle as resync → the new value is used by that ALIGN.
- Async reset mid-period: assert rst_n low mid-period → ce, clk_out and locked go to 0 without waiting for a clock edge. After release, default timing resumes exactly as in scenario 1.
- Back-to-back resync on consecutive cycles → ALIGN repeats. Timing is measured from the last ALIGN cycle, with no spurious ce pulses in between.
